uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame, range 5..8.
REQ-002 Parameter STOP_BITS, default 1: number of stop-bit periods, range 1..2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-cycle bit-period pulse from the upstream delay/divider rdy output.
REQ-006 data  input  DATA_BITS  byte to send; sampled only on acceptance.
REQ-007 valid  input  1  data holds a byte to send.
REQ-008 ready  output  1  block can accept a byte this cycle.
REQ-009 tick_en  output  1  enable for the upstream divider; high while a frame is in progress.
REQ-010 tick_clr  output  1  one-cycle pulse that restarts the divider count on frame start.
REQ-011 tx  output  1  serial line, idle high.
REQ-012 busy  output  1  frame in progress.
REQ-013 done  output  1  one-cycle pulse when the final stop period ends.

Function
REQ-014 The state machine SHALL have the states IDLE, START, DATA, PARITY (present only with the macro) and STOP.
REQ-015 Acceptance SHALL occur on a rising edge where valid=1 and ready=1; ready SHALL equal 1 only in IDLE.
REQ-016 On acceptance, data SHALL be latched into a shift register, the state SHALL become START, tx SHALL become 0 and busy SHALL become 1, all in the same edge.
REQ-017 tick_clr SHALL be high for exactly the cycle after acceptance; tick_en SHALL be high whenever state is not IDLE.
REQ-018 Each state SHALL hold tx constant until a cycle with tick=1, then advance at that edge.
REQ-019 START on tick SHALL transition to DATA with tx = bit 0; data SHALL go LSB first.
REQ-020 DATA SHALL shift one bit per tick; after DATA_BITS ticks it SHALL go to PARITY if the macro is defined, otherwise to STOP with tx=1.
REQ-021 STOP SHALL count STOP_BITS ticks at tx=1; on the last tick it SHALL go to IDLE, with ready=1, busy=0, and done=1 for one cycle.
REQ-022 A tick in IDLE SHALL be ignored; valid while not in IDLE SHALL be ignored and not queued.
REQ-023 A change on data after acceptance SHALL NOT affect the frame in progress.
REQ-024 A byte presented in the done cycle SHALL be accepted on that edge (back-to-back frames, no extra idle bit).
REQ-025 The bit counter SHALL be ceil(log2(DATA_BITS+1)) wide and SHALL reset to 0 on every acceptance.

Reset
REQ-026 While rst=0, outputs SHALL be: tx=1, ready=0, busy=0, done=0, tick_en=0, tick_clr=0; the state SHALL be IDLE and the counters 0.
REQ-027 ready SHALL rise on the first rising edge after rst deasserts.
REQ-028 Reset assertion mid-frame SHALL force tx=1 immediately (asynchronously) and abandon the frame without a done pulse.

Configuration
REQ-029 Macro UART_TX_PARITY_EN: when defined, the PARITY state SHALL transmit one even-parity bit (XOR of the data bits) for one tick period between DATA and STOP.
REQ-030 When UART_TX_PARITY_EN is undefined, no parity logic or state SHALL exist, and the frame SHALL be 1 + DATA_BITS + STOP_BITS periods.

Verification
REQ-031 Reset, then data=0x55 with valid pulsed and a tick every 10 clk -> tx = 0,1,0,1,0,1,0,1,0,1, each held 10 clk; done pulses once; tick_clr pulses once.
REQ-032 UART_TX_PARITY_EN defined, data=0x01 -> parity bit 1; data=0x55 -> parity bit 0; frame is 11 periods.
REQ-033 valid held high with 0xA3 then 0x3C -> two contiguous frames; the second start bit begins the cycle after done; no idle gap.
REQ-034 valid asserted mid-frame, and tick asserted while idle -> no acceptance; ready stays 0 until done; idle ticks cause no tx change.
REQ-035 rst asserted during the 4th data bit -> tx=1 the same cycle; busy=0; no done; the next byte is sent correctly after release.
REQ-036 STOP_BITS=2, DATA_BITS=7, data=0x7F -> 0,1×7,1,1; busy spans exactly 10 tick periods.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, 1 start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
// Latency: the start bit is driven on the accepting edge; each later bit advances on a tick.
// Backpressure: ready is high only in IDLE; valid outside IDLE is dropped. Optional even parity: define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tick_en,
  output logic                 tick_clr,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W  = $clog2(DATA_BITS + 1);
  localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  // Last data-bit count and last stop-period index, sized to their counters.
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [STOP_W-1:0]    stop_cnt;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // Frame sequencer: every output is a register so the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      tx         <= 1'b1;
      ready      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tick_en    <= 1'b0;
      tick_clr   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      // Pulses default low; they are raised only on the edge that creates them.
      done     <= 1'b0;
      tick_clr <= 1'b0;
      case (state)
        IDLE: begin
          // ready rises on the first edge out of reset and stays up while idle.
          ready <= 1'b1;
          if (valid && ready) begin
            shift_reg  <= data;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            ready      <= 1'b0;
            tick_en    <= 1'b1;
            tick_clr   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data;
`endif
          end
        end

        START: begin
          if (tick) begin
            state     <= DATA;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= CNT_W'(1);
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            if (stop_cnt == STOP_LAST) begin
              state    <= IDLE;
              ready    <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              tick_en  <= 1'b0;
              stop_cnt <= '0;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end

        default: begin
          // Unused encodings recover to a quiet idle line.
          state   <= IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
          ready   <= 1'b0;
          tick_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
